// File: rtl/bmem_arbiter.sv
// Single-port tile-memory arbiter: VGA fetch, buffered game writes and game reads share one port.
// VGA wins during active video; game reads wait until every buffered write has drained.
module bmem_arbiter #(
  parameter int unsigned AddrW     = 10,
  parameter int unsigned DataW     = 4,
  parameter int unsigned FifoDepth = 4,
  localparam int unsigned PtrW     = $clog2(FifoDepth),
  localparam int unsigned CntW     = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             vga_blank_i,
  input  logic             vga_re_i,
  input  logic [AddrW-1:0] vga_raddr_i,
  output logic [DataW-1:0] vga_rdata_o,
  output logic             vga_rvalid_o,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [AddrW-1:0] wr_addr_i,
  input  logic [DataW-1:0] wr_data_i,
  input  logic             rd_valid_i,
  output logic             rd_ready_o,
  input  logic [AddrW-1:0] rd_addr_i,
  output logic [DataW-1:0] rd_data_o,
  output logic             rd_resp_o,
  output logic [CntW-1:0]  fifo_count_o,
  output logic             mem_en_o,
  output logic             mem_we_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [DataW-1:0] mem_wdata_o,
  input  logic [DataW-1:0] mem_rdata_i
);

  typedef enum logic [1:0] {OwnNone, OwnVga, OwnGame} owner_e;

  // Write buffer storage and pointers
  logic [AddrW-1:0] fifo_addr_q [FifoDepth];
  logic [DataW-1:0] fifo_data_q [FifoDepth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;

  owner_e           owner_q, owner_d;
  logic [DataW-1:0] rd_data_q, rd_data_d;
  logic             rd_resp_q, rd_resp_d;

  logic             push, pop, fifo_busy;
  logic             gnt_vga, gnt_fifo, gnt_rd;
  logic [AddrW-1:0] head_addr;
  logic [DataW-1:0] head_data;

  assign fifo_busy  = (count_q != '0);
  assign wr_ready_o = (count_q < CntW'(FifoDepth));
  assign push       = wr_valid_i & wr_ready_o;
  assign pop        = gnt_fifo;
  assign head_addr  = fifo_addr_q[rptr_q];
  assign head_data  = fifo_data_q[rptr_q];

  // One owner per cycle; nothing is granted while reset is held so the port stays idle.
  always_comb begin
    gnt_vga  = 1'b0;
    gnt_fifo = 1'b0;
    gnt_rd   = 1'b0;
    if (rst_ni) begin
      if (!vga_blank_i) begin
        if (vga_re_i) begin
          gnt_vga = 1'b1;
        end else if (fifo_busy) begin
          gnt_fifo = 1'b1;
        end else if (rd_valid_i) begin
          gnt_rd = 1'b1;
        end
      end else begin
        if (fifo_busy) begin
          gnt_fifo = 1'b1;
        end else if (rd_valid_i) begin
          gnt_rd = 1'b1;
        end else if (vga_re_i) begin
          gnt_vga = 1'b1;
        end
      end
    end
  end

  always_comb begin
    mem_en_o    = gnt_vga | gnt_fifo | gnt_rd;
    mem_we_o    = gnt_fifo;
    mem_addr_o  = vga_raddr_i;
    mem_wdata_o = head_data;
    rd_ready_o  = gnt_rd;
    if (gnt_fifo) begin
      mem_addr_o = head_addr;
    end else if (gnt_rd) begin
      mem_addr_o = rd_addr_i;
    end
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push) begin
      wptr_d = wptr_q + PtrW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PtrW'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Response tag follows the read owner; the tagged cycle sees mem_rdata for that read.
  always_comb begin
    owner_d   = OwnNone;
    rd_data_d = rd_data_q;
    rd_resp_d = 1'b0;
    if (gnt_vga) begin
      owner_d = OwnVga;
    end else if (gnt_rd) begin
      owner_d = OwnGame;
    end
    if (owner_q == OwnGame) begin
      rd_data_d = mem_rdata_i;
      rd_resp_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      owner_q   <= OwnNone;
      rd_data_q <= '0;
      rd_resp_q <= 1'b0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      owner_q   <= owner_d;
      rd_data_q <= rd_data_d;
      rd_resp_q <= rd_resp_d;
    end
  end

  // Buffer payload needs no reset; occupancy is tracked by the pointers.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr_q[wptr_q] <= wr_addr_i;
      fifo_data_q[wptr_q] <= wr_data_i;
    end
  end

  assign vga_rvalid_o = (owner_q == OwnVga);
  assign vga_rdata_o  = mem_rdata_i;
  assign rd_data_o    = rd_data_q;
  assign rd_resp_o    = rd_resp_q;
  assign fifo_count_o = count_q;

endmodule

// File: tb/tb_bmem_arbiter.sv
// Directed bench for bmem_arbiter with a behavioural 1k x 4 tile memory behind the port.
module tb_bmem_arbiter;
  localparam int AW = 10;
  localparam int DW = 4;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          vga_blank, vga_re;
  logic [AW-1:0] vga_raddr;
  logic [DW-1:0] vga_rdata;
  logic          vga_rvalid;
  logic          wr_valid, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_valid, rd_ready;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_resp;
  logic [CW-1:0] fifo_count;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          init_mem;
  logic [DW-1:0] bmem [1024];

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  bmem_arbiter dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .vga_blank_i (vga_blank),
    .vga_re_i    (vga_re),
    .vga_raddr_i (vga_raddr),
    .vga_rdata_o (vga_rdata),
    .vga_rvalid_o(vga_rvalid),
    .wr_valid_i  (wr_valid),
    .wr_ready_o  (wr_ready),
    .wr_addr_i   (wr_addr),
    .wr_data_i   (wr_data),
    .rd_valid_i  (rd_valid),
    .rd_ready_o  (rd_ready),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .rd_resp_o   (rd_resp),
    .fifo_count_o(fifo_count),
    .mem_en_o    (mem_en),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  // Preload: addresses 0..31 hold (a*5+3) mod 16, everything else 0x9.
  function automatic logic [DW-1:0] pat(input int a);
    if (a < 32) return DW'((a * 5 + 3) & 15);
    return 4'h9;
  endfunction

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 1024; i++) bmem[i] <= pat(i);
    end else if (mem_en) begin
      if (mem_we) bmem[mem_addr] <= mem_wdata;
      else        mem_rdata <= bmem[mem_addr];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; init_mem = 1'b1;
    vga_blank = 1'b0; vga_re = 1'b1; vga_raddr = 10'h155;
    wr_valid = 1'b1; wr_addr = 10'h3FF; wr_data = 4'hF;
    rd_valid = 1'b1; rd_addr = 10'h0AA;
    for (int c = 0; c < 2; c++) begin
      step();
      init_mem = 1'b0;
      #1;
      vecs++; if (mem_en !== 1'b0) begin errs++; $display("FAIL reset_mem_en: got %b want 0", mem_en); end
      vecs++; if (rd_ready !== 1'b0) begin errs++; $display("FAIL reset_rd_ready: got %b want 0", rd_ready); end
      vecs++; if (wr_ready !== 1'b1) begin errs++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
      vecs++; if (fifo_count !== 3'd0) begin errs++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
      vecs++; if (vga_rvalid !== 1'b0) begin errs++; $display("FAIL reset_rvalid: got %b want 0", vga_rvalid); end
      vecs++; if (rd_resp !== 1'b0) begin errs++; $display("FAIL reset_rd_resp: got %b want 0", rd_resp); end
      vecs++; if (rd_data !== 4'h0) begin errs++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    end
    rst_n = 1'b1;
    #1;
    vecs++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'h155 || rd_ready !== 1'b0) begin
      errs++; $display("FAIL first_grant_vga: en=%b we=%b addr=%h rd_ready=%b want en=1 we=0 addr=155 rd_ready=0",
                       mem_en, mem_we, mem_addr, rd_ready);
    end
    step();
    wr_valid = 1'b0; rd_valid = 1'b0; vga_re = 1'b0; vga_blank = 1'b1;
    #1;
    vecs++; if (vga_rvalid !== 1'b1) begin errs++; $display("FAIL first_vga_rvalid: got %b want 1", vga_rvalid); end
    vecs++; if (fifo_count !== 3'd1) begin errs++; $display("FAIL first_push_count: got %0d want 1", fifo_count); end
    vecs++; if (mem_we !== 1'b1 || mem_addr !== 10'h3FF || mem_wdata !== 4'hF) begin
      errs++; $display("FAIL first_drain: we=%b addr=%h wdata=%h want we=1 addr=3ff wdata=f", mem_we, mem_addr, mem_wdata);
    end
    step();
    vecs++; if (fifo_count !== 3'd0 || mem_en !== 1'b0 || vga_rvalid !== 1'b0) begin
      errs++; $display("FAIL post_reset_idle: count=%0d en=%b rvalid=%b want 0 0 0", fifo_count, mem_en, vga_rvalid);
    end
  endtask

  task automatic test_active_priority();
    int k = 0;
    logic acc;
    vga_blank = 1'b0; vga_re = 1'b1; vga_raddr = 10'h010;
    for (int c = 0; c < 8; c++) begin
      if (k < 5) begin wr_valid = 1'b1; wr_addr = 10'h100 + AW'(k); wr_data = DW'(k + 1); end
      else wr_valid = 1'b0;
      #1;
      vecs++; if (mem_we !== 1'b0 || mem_en !== 1'b1) begin
        errs++; $display("FAIL active_no_write c%0d: en=%b we=%b want en=1 we=0", c, mem_en, mem_we);
      end
      if (c == 0) begin
        vecs++; if (vga_rvalid !== 1'b0) begin errs++; $display("FAIL active_first_rvalid: got %b want 0", vga_rvalid); end
      end else begin
        vecs++; if (vga_rvalid !== 1'b1 || vga_rdata !== 4'h3) begin
          errs++; $display("FAIL active_rvalid c%0d: rvalid=%b data=%h want 1 3", c, vga_rvalid, vga_rdata);
        end
      end
      acc = wr_valid & wr_ready;
      step();
      if (acc) k++;
    end
    #1;
    vecs++; if (k !== 4) begin errs++; $display("FAIL active_accepted: got %0d want 4", k); end
    vecs++; if (fifo_count !== 3'd4) begin errs++; $display("FAIL active_count: got %0d want 4", fifo_count); end
    vecs++; if (wr_ready !== 1'b0) begin errs++; $display("FAIL active_wr_ready: got %b want 0", wr_ready); end
  endtask

  task automatic test_blank_drain();
    logic acc;
    logic got5 = 1'b0;
    vga_blank = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      vecs++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 10'h100 + AW'(c) || mem_wdata !== DW'(c + 1)) begin
        errs++; $display("FAIL drain c%0d: en=%b we=%b addr=%h wdata=%h want 1 1 %h %h",
                         c, mem_en, mem_we, mem_addr, mem_wdata, 10'h100 + AW'(c), DW'(c + 1));
      end
      if (c == 0) begin
        vecs++; if (wr_ready !== 1'b0) begin errs++; $display("FAIL drain_full_ready: got %b want 0", wr_ready); end
      end else begin
        vecs++; if (vga_rvalid !== 1'b0) begin errs++; $display("FAIL drain_vga_blocked c%0d: got %b want 0", c, vga_rvalid); end
      end
      acc = wr_valid & wr_ready;
      step();
      if (acc) begin wr_valid = 1'b0; got5 = 1'b1; end
    end
    #1;
    vecs++; if (got5 !== 1'b1) begin errs++; $display("FAIL drain_fifth_accepted: got %b want 1", got5); end
    vecs++; if (fifo_count !== 3'd0 || mem_we !== 1'b0 || mem_en !== 1'b1 || mem_addr !== 10'h010) begin
      errs++; $display("FAIL drain_then_vga: count=%0d en=%b we=%b addr=%h want 0 1 0 010", fifo_count, mem_en, mem_we, mem_addr);
    end
    step();
    vga_re = 1'b0;
    #1;
    vecs++; if (vga_rvalid !== 1'b1 || mem_en !== 1'b0) begin
      errs++; $display("FAIL drain_vga_served: rvalid=%b en=%b want 1 0", vga_rvalid, mem_en);
    end
    step();
  endtask

  task automatic test_read_after_write();
    vga_blank = 1'b1; vga_re = 1'b0;
    wr_valid = 1'b1; wr_addr = 10'h02A; wr_data = 4'h7; rd_valid = 1'b0;
    #1;
    vecs++; if (wr_ready !== 1'b1 || mem_en !== 1'b0) begin
      errs++; $display("FAIL raw_push: ready=%b en=%b want 1 0", wr_ready, mem_en);
    end
    step();
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 10'h02A;
    #1;
    vecs++; if (rd_ready !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 10'h02A || fifo_count !== 3'd1) begin
      errs++; $display("FAIL raw_write_first: rd_ready=%b we=%b addr=%h count=%0d want 0 1 02a 1",
                       rd_ready, mem_we, mem_addr, fifo_count);
    end
    step();
    #1;
    vecs++; if (rd_ready !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 10'h02A) begin
      errs++; $display("FAIL raw_grant: rd_ready=%b en=%b we=%b addr=%h want 1 1 0 02a", rd_ready, mem_en, mem_we, mem_addr);
    end
    step();
    rd_valid = 1'b0;
    #1;
    vecs++; if (rd_resp !== 1'b0) begin errs++; $display("FAIL raw_resp_early: got %b want 0", rd_resp); end
    step();
    vecs++; if (rd_resp !== 1'b1 || rd_data !== 4'h7) begin
      errs++; $display("FAIL raw_resp: resp=%b data=%h want 1 7", rd_resp, rd_data);
    end
    step();
    vecs++; if (rd_resp !== 1'b0 || rd_data !== 4'h7) begin
      errs++; $display("FAIL raw_resp_pulse: resp=%b data=%h want 0 7", rd_resp, rd_data);
    end
  endtask

  task automatic test_back_to_back();
    vga_blank = 1'b0;
    for (int c = 0; c <= 32; c++) begin
      if (c < 32) begin vga_re = 1'b1; vga_raddr = AW'(c); end
      else vga_re = 1'b0;
      #1;
      if (c == 0) begin
        vecs++; if (vga_rvalid !== 1'b0) begin errs++; $display("FAIL pipe_start: rvalid=%b want 0", vga_rvalid); end
      end else begin
        vecs++; if (vga_rvalid !== 1'b1 || vga_rdata !== pat(c - 1)) begin
          errs++; $display("FAIL pipe_data a%0d: rvalid=%b data=%h want 1 %h", c - 1, vga_rvalid, vga_rdata, pat(c - 1));
        end
      end
      step();
    end
    #1;
    vecs++; if (vga_rvalid !== 1'b0) begin errs++; $display("FAIL pipe_end: rvalid=%b want 0", vga_rvalid); end
  endtask

  task automatic test_reset_mid_read();
    vga_blank = 1'b1; vga_re = 1'b0;
    rd_valid = 1'b1; rd_addr = 10'h02A;
    wr_valid = 1'b1; wr_addr = 10'h02B; wr_data = 4'h5;
    #1;
    vecs++; if (rd_ready !== 1'b1 || wr_ready !== 1'b1) begin
      errs++; $display("FAIL mid_grant: rd_ready=%b wr_ready=%b want 1 1", rd_ready, wr_ready);
    end
    step();
    rd_valid = 1'b0; wr_valid = 1'b0; rst_n = 1'b0;
    #1;
    vecs++; if (mem_en !== 1'b0 || fifo_count !== 3'd1) begin
      errs++; $display("FAIL mid_in_reset: en=%b count=%0d want 0 1", mem_en, fifo_count);
    end
    step();
    rst_n = 1'b1;
    #1;
    vecs++; if (rd_resp !== 1'b0 || rd_data !== 4'h0 || fifo_count !== 3'd0 || vga_rvalid !== 1'b0 || mem_en !== 1'b0) begin
      errs++; $display("FAIL mid_after_reset: resp=%b data=%h count=%0d rvalid=%b en=%b want 0 0 0 0 0",
                       rd_resp, rd_data, fifo_count, vga_rvalid, mem_en);
    end
    step();
    vecs++; if (rd_resp !== 1'b0 || rd_data !== 4'h0) begin
      errs++; $display("FAIL mid_no_late_resp: resp=%b data=%h want 0 0", rd_resp, rd_data);
    end
  endtask

  initial begin
    test_reset();
    test_active_priority();
    test_blank_drain();
    test_read_after_write();
    test_back_to_back();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/bmem_arbiter.md
# bmem_arbiter

Single-port arbiter for the 1k-entry tile block memory (32×24 tiles, address = {row[4:0], col[4:0]}), shared between the VGA fetch path and the snake game engine. The VGA fetch path gets strict priority during active video. Game writes are buffered in a small FIFO and drained in free cycles. Game reads are granted only when no buffered write is pending, so a read always returns the latest written value.

## Interface
Parameters:
- ADDR_W, 10, tile memory address width
- DATA_W, 4, tile code width
- FIFO_DEPTH, 4, game write buffer entries (power of two, ≥2)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-low (reset=0 clears state on the next rising edge)
- vga_blank  in  1  1 = display outside active video
- vga_re  in  1  VGA read request
- vga_raddr  in  ADDR_W  VGA read address
- vga_rdata  out  DATA_W  VGA read data
- vga_rvalid  out  1  vga_rdata valid this cycle
- wr_valid  in  1  game write request
- wr_ready  out  1  write buffer can accept
- wr_addr  in  ADDR_W  game write address
- wr_data  in  DATA_W  game write data
- rd_valid  in  1  game read request, held until accepted
- rd_ready  out  1  game read granted this cycle
- rd_addr  in  ADDR_W  game read address
- rd_data  out  DATA_W  registered game read result
- rd_resp  out  1  one-cycle pulse, rd_data updated
- fifo_count  out  clog2(FIFO_DEPTH)+1  buffered writes
- mem_en, mem_we  out  1  memory port enable / write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid 1 cycle after a read with mem_en=1, mem_we=0

## Operation
- Write FIFO:
  - Push when wr_valid & wr_ready.
  - wr_ready = (fifo_count < FIFO_DEPTH). This is combinational on the current count only; a same-cycle pop does not free a slot.
  - Pop when the FIFO head is granted.
- Per-cycle grant, one owner per cycle:
  - vga_blank=0: VGA (if vga_re), else FIFO head (if count>0), else game read (if rd_valid & count==0).
  - vga_blank=1: FIFO head, else game read (rd_valid & count==0), else VGA.
- Port drive:
  - VGA grant: mem_en=1, mem_we=0, mem_addr=vga_raddr.
  - FIFO grant: mem_en=1, mem_we=1, mem_addr/wdata from the FIFO head.
  - Read grant: mem_en=1, mem_we=0, mem_addr=rd_addr, rd_ready=1.
  - No grant: mem_en=0, mem_we=0.
- Response tag register owner_q ∈ {NONE, VGA, GAME}:
  - Loaded each cycle with the read owner; NONE on write or idle cycles.
  - owner_q==VGA: vga_rvalid=1 and vga_rdata=mem_rdata (combinational passthrough). vga_rdata is don't-care when vga_rvalid=0.
  - owner_q==GAME: rd_data<=mem_rdata and rd_resp=1 on the following cycle.
- An ungranted VGA request during blank is dropped. The requester keeps vga_re high and is served on the first free cycle. No queuing.
- Coherency:
  - A game read never overtakes a buffered write.
  - A VGA read sees a write only after it has been drained.

## Timing
- Reset values: fifo_count=0, wr_ready=1, owner_q=NONE, vga_rvalid=0, rd_ready=0, rd_resp=0, rd_data=0, mem_en=0, mem_we=0.
- Reset mid-operation:
  - FIFO contents are discarded.
  - An in-flight read produces no vga_rvalid or rd_resp after the reset edge.
- VGA read latency: request in cycle N, vga_rvalid in N+1 when granted in N.
- Game read latency:
  - rd_ready in the grant cycle G.
  - rd_resp and new rd_data visible in G+2: owner_q is set at the G edge, rd_data is captured at the G+1 edge.
- Write drain latency: a push in cycle N, when idle with an empty FIFO, is written in N+1.
- Active video with continuous vga_re: zero game grants. Writes accumulate until wr_ready=0. wr_valid must be held until accepted.
- Back-to-back reads of any owner are fully pipelined, one per cycle.
- Combinational paths:
  - rd_ready, wr_ready and the mem_* outputs depend combinationally on inputs.
  - vga_rvalid, rd_resp and rd_data come from registers only. vga_rdata passes mem_rdata through combinationally.

## Test plan
- Reset: hold reset=0 for 2 cycles with all requests active → mem_en=0, wr_ready=1, fifo_count=0, no rvalid/resp. After release, first grant follows the priority order.
- Active-video priority:
  - Setup: vga_blank=0, vga_re=1 constant, 5 game writes offered.
  - Required: 4 accepted (fifo_count=4, wr_ready=0), no mem_we pulses, vga_rvalid=1 every cycle after the first.
- Blank drain: then vga_blank=1 → 4 consecutive mem_we cycles in FIFO order. The 5th write is accepted once count<4. VGA is served only after the FIFO is empty.
- Read-after-write:
  - Setup: write addr 0x2A=0x7, immediately request a read of 0x2A during blank.
  - Required: rd_ready held low until the write drains. rd_resp 2 cycles after grant with rd_data=0x7.
- Pipelining: vga_blank=0, VGA reads 0x000..0x01F back-to-back against a preloaded memory → vga_rvalid on 32 consecutive cycles, data in address order.
- Reset mid-read: assert reset=0 in the cycle a game read is granted → no rd_resp afterwards, rd_data=0, FIFO empty.
